mips_bus_arbiter: RTL and testbench

- Shares the CPU's single Avalon-style memory master port (address/read/write/waitrequest/writedata/byteenable/readdata) between two requesters: the instruction-fetch port and the load/store data port.
- Sits between the CPU core and mips_cpu_ram.
- Serialises transactions and grants by fixed or round-robin priority.
- Forwards each transaction's waitrequest and readdata to the owning requester only, and flags stalled memory with a watchdog.

---
 rtl/mips_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Shares one Avalon-style memory master port between the
//               instruction-fetch port and the load/store data port. Grants
//               by fixed (data first) or round-robin priority, routes
//               waitrequest/readdata to the owner only, and raises a sticky
//               watchdog flag when memory stalls one transaction too long.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active-low
  // instruction-fetch port
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  // load/store data port
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  // memory master port
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  // watchdog
  output logic        timeout_err
);

  localparam int         CW         = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic       C_OWNER_I  = 1'b0;
  localparam logic       C_OWNER_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_last_owner;
  logic [CW-1:0]   r_count;
  logic            r_timeout_err;

  logic            w_d_req;
  logic            w_strobe;     // granted port's strobe, as seen on the bus
  logic            w_done;       // transaction completes this cycle
  logic            w_owned;

  assign w_d_req = d_read | d_write;
  assign w_owned = (r_state != IDLE);
  assign w_done  = w_owned & w_strobe & ~waitrequest;

  // State register, last owner, stall counter and sticky watchdog flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last_owner  <= C_OWNER_I;
      r_count       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_done) begin
        r_last_owner <= (r_state == GRANT_D) ? C_OWNER_D : C_OWNER_I;
      end
      if (w_owned && w_strobe && waitrequest) begin
        // Saturate so a permanently stuck memory cannot wrap the counter
        if (r_count != C_CNT_MAX) begin
          r_count <= r_count + 1'b1;
        end
        if (r_count == C_CNT_MAX) begin
          r_timeout_err <= 1'b1;
        end
      end else begin
        // Either idle, completing or withdrawn: every exit starts fresh
        r_count <= '0;
      end
    end
  end

  // Next-state arbitration and memory-side / requester-side muxing
  always_comb begin
    w_next_state  = r_state;
    w_strobe      = 1'b0;
    address       = 32'd0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = 32'd0;
    byteenable    = 4'd0;
    i_readdata    = 32'd0;
    d_readdata    = 32'd0;

    case (r_state)
      IDLE: begin
        if (w_d_req && i_read) begin
          if (ROUND_ROBIN != 0) begin
            w_next_state = (r_last_owner == C_OWNER_I) ? GRANT_D : GRANT_I;
          end else begin
            w_next_state = GRANT_D;
          end
        end else if (w_d_req) begin
          w_next_state = GRANT_D;
        end else if (i_read) begin
          w_next_state = GRANT_I;
        end
      end
      GRANT_I: begin
        w_strobe   = i_read;
        address    = i_address;
        read       = i_read;
        byteenable = 4'b1111;
        if (w_done) begin
          i_readdata = readdata;
        end
        if (!w_strobe || w_done) begin
          w_next_state = IDLE;
        end
      end
      GRANT_D: begin
        w_strobe   = w_d_req;
        address    = d_address;
        write      = d_write;
        read       = d_read & ~d_write;   // write wins a read/write collision
        byteenable = d_byteenable;
        writedata  = d_writedata;
        if (w_done) begin
          d_readdata = readdata;
        end
        if (!w_strobe || w_done) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign i_waitrequest = !((r_state == GRANT_I) && !waitrequest);
  assign d_waitrequest = !((r_state == GRANT_D) && !waitrequest);
  assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Directed self-checking bench for mips_bus_arbiter. One
//               round-robin instance and one fixed-priority instance share
//               all inputs; both use a short watchdog of 4 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read;
  logic [31:0] i_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  // round-robin instance outputs
  logic        i_waitrequest, d_waitrequest, read, write, timeout_err;
  logic [31:0] i_readdata, d_readdata, address, writedata;
  logic [3:0]  byteenable;
  // fixed-priority instance outputs
  logic        fp_i_waitrequest, fp_d_waitrequest, fp_read, fp_write, fp_timeout_err;
  logic [31:0] fp_i_readdata, fp_d_readdata, fp_address, fp_writedata;
  logic [3:0]  fp_byteenable;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .timeout_err(timeout_err)
  );

  mips_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(4)) dut_fp (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address),
    .i_waitrequest(fp_i_waitrequest), .i_readdata(fp_i_readdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(fp_d_waitrequest), .d_readdata(fp_d_readdata),
    .address(fp_address), .read(fp_read), .write(fp_write),
    .writedata(fp_writedata), .byteenable(fp_byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .timeout_err(fp_timeout_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    i_read = 0; i_address = 0; d_read = 0; d_write = 0; d_address = 0;
    d_writedata = 0; d_byteenable = 0; waitrequest = 0; readdata = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({read, write, address, writedata, byteenable} !== 70'd0) begin
      failures++;
      $display("FAIL reset_bus: got r=%b w=%b a=%h wd=%h be=%b, want all zero",
               read, write, address, writedata, byteenable);
    end
    checks++;
    if ({i_waitrequest, d_waitrequest, timeout_err} !== 3'b110) begin
      failures++;
      $display("FAIL reset_flags: got iw=%b dw=%b to=%b, want 1 1 0",
               i_waitrequest, d_waitrequest, timeout_err);
    end
  endtask

  task automatic test_fetch;
    do_reset();
    i_read = 1; i_address = 32'hBFC00000; readdata = 32'h12345678;
    #1;
    checks++;
    if (read !== 1'b0 || i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL fetch_cycle1: got r=%b iw=%b dw=%b, want 0 1 1",
               read, i_waitrequest, d_waitrequest);
    end
    step();
    checks++;
    if (read !== 1'b1 || write !== 1'b0 || address !== 32'hBFC00000 ||
        byteenable !== 4'b1111 || i_waitrequest !== 1'b0 || d_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL fetch_cycle2: got r=%b w=%b a=%h be=%b iw=%b dw=%b, want 1 0 bfc00000 1111 0 1",
               read, write, address, byteenable, i_waitrequest, d_waitrequest);
    end
    checks++;
    if (i_readdata !== 32'h12345678 || d_readdata !== 32'd0) begin
      failures++;
      $display("FAIL fetch_data: got i_rd=%h d_rd=%h, want 12345678 00000000",
               i_readdata, d_readdata);
    end
    i_read = 0;
    step();
    checks++;
    if (read !== 1'b0 || address !== 32'd0) begin
      failures++;
      $display("FAIL fetch_idle: got r=%b a=%h, want 0 00000000", read, address);
    end
  endtask

  task automatic test_stalled_write;
    do_reset();
    d_write = 1; d_address = 32'h10; d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011;
    waitrequest = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      waitrequest = (k < 4);
      #1;
      checks++;
      if (write !== 1'b1 || address !== 32'h10 || writedata !== 32'hDEADBEEF ||
          byteenable !== 4'b0011 || d_waitrequest !== (k < 4) || i_waitrequest !== 1'b1) begin
        failures++;
        $display("FAIL stall_write_%0d: got w=%b a=%h wd=%h be=%b dw=%b iw=%b, want 1 10 deadbeef 0011 %0d 1",
                 k, write, address, writedata, byteenable, d_waitrequest, i_waitrequest, (k < 4));
      end
    end
    d_write = 0;
    step();
    checks++;
    if (write !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL stall_write_end: got w=%b to=%b, want 0 0", write, timeout_err);
    end
  endtask

  task automatic test_arbitration;
    logic exp_d;
    do_reset();
    i_read = 1; d_read = 1; i_address = 32'h100; d_address = 32'h200;
    readdata = 32'hAAAA5555; waitrequest = 0;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2 == 0);
      step();
      checks++;
      if (d_waitrequest !== !exp_d || i_waitrequest !== exp_d ||
          address !== (exp_d ? 32'h200 : 32'h100) ||
          d_readdata !== (exp_d ? 32'hAAAA5555 : 32'd0) ||
          i_readdata !== (exp_d ? 32'd0 : 32'hAAAA5555)) begin
        failures++;
        $display("FAIL rr_grant_%0d: got dw=%b iw=%b a=%h, want dw=%b iw=%b",
                 t, d_waitrequest, i_waitrequest, address, !exp_d, exp_d);
      end
      checks++;
      if (fp_d_waitrequest !== 1'b0 || fp_i_waitrequest !== 1'b1 || fp_address !== 32'h200) begin
        failures++;
        $display("FAIL fp_grant_%0d: got dw=%b iw=%b a=%h, want 0 1 00000200",
                 t, fp_d_waitrequest, fp_i_waitrequest, fp_address);
      end
      step();
      checks++;
      if (read !== 1'b0 || fp_read !== 1'b0 || d_waitrequest !== 1'b1 || i_waitrequest !== 1'b1) begin
        failures++;
        $display("FAIL idle_gap_%0d: got r=%b fp_r=%b dw=%b iw=%b, want 0 0 1 1",
                 t, read, fp_read, d_waitrequest, i_waitrequest);
      end
    end
    d_read = 0;
    step();
    checks++;
    if (fp_i_waitrequest !== 1'b0 || fp_address !== 32'h100) begin
      failures++;
      $display("FAIL fp_fetch_after_d: got iw=%b a=%h, want 0 00000100",
               fp_i_waitrequest, fp_address);
    end
    i_read = 0;
    step();
  endtask

  task automatic test_rw_conflict;
    // Runs right after a 3-stall write in a fresh reset: counter must have cleared
    do_reset();
    d_write = 1; d_address = 32'h40; waitrequest = 1; d_byteenable = 4'hF;
    step(); step(); step(); step();
    waitrequest = 0;
    step();
    d_write = 0;
    step();
    d_read = 1; d_write = 1; d_address = 32'h44; d_writedata = 32'h0BADF00D;
    waitrequest = 1;
    step();
    checks++;
    if (write !== 1'b1 || read !== 1'b0 || writedata !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL rw_conflict: got w=%b r=%b wd=%h, want 1 0 0badf00d", write, read, writedata);
    end
    step();
    waitrequest = 0;
    step();
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL counter_clear: got to=%b, want 0", timeout_err);
    end
    d_read = 0; d_write = 0;
    step();
  endtask

  task automatic test_timeout;
    do_reset();
    d_read = 1; d_address = 32'h80; waitrequest = 1; readdata = 32'hCAFE0001;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (timeout_err !== (k == 4)) begin
        failures++;
        $display("FAIL timeout_stall_%0d: got to=%b, want %0d", k, timeout_err, (k == 4));
      end
    end
    waitrequest = 0;
    #1;
    checks++;
    if (d_waitrequest !== 1'b0 || d_readdata !== 32'hCAFE0001) begin
      failures++;
      $display("FAIL timeout_complete: got dw=%b d_rd=%h, want 0 cafe0001", d_waitrequest, d_readdata);
    end
    d_read = 0;
    step();
    step();
    checks++;
    if (timeout_err !== 1'b1 || read !== 1'b0) begin
      failures++;
      $display("FAIL timeout_sticky: got to=%b r=%b, want 1 0", timeout_err, read);
    end
    do_reset();
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reset: got to=%b, want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    d_write = 1; d_address = 32'hC0; waitrequest = 1;
    step(); step(); step();
    #2;
    checks++;
    if (write !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: got w=%b, want 1", write);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (write !== 1'b0 || read !== 1'b0 || d_waitrequest !== 1'b1 || address !== 32'd0) begin
      failures++;
      $display("FAIL mid_async_drop: got w=%b r=%b dw=%b a=%h, want 0 0 1 0",
               write, read, d_waitrequest, address);
    end
    d_write = 0;
    step();
    reset = 1'b1;
    d_write = 1;
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (timeout_err !== 1'b0 || write !== 1'b1) begin
        failures++;
        $display("FAIL mid_counter_%0d: got to=%b w=%b, want 0 1", k, timeout_err, write);
      end
    end
    waitrequest = 0;
    step();
    d_write = 0;
    step();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_fetch();
    test_stalled_write();
    test_arbitration();
    test_rw_conflict();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
